gcore_seq: RTL and testbench

Multi-cycle instruction sequencer for the GCore accumulator datapath. It fetches an opcode byte and, when the instruction needs one, an operand byte over a ready-handshaked byte memory port. It then steps the datapath through execute, memory and write-back phases by driving PC, IR, operand, memory and accumulator control strobes. It sits between program/data memory and the accumulator/ALU/PC registers, and supplies the per-cycle control those registers need.

---
 rtl/gcore_seq.sv | 150 +++++++++++++++
 tb/tb_gcore_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gcore_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the GCore accumulator datapath.
// Optional single-step control is enabled by defining GCORE_SEQ_STEP_EN.
module gcore_seq (
  input  logic       clk,
  input  logic       rst_n,
`ifdef GCORE_SEQ_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  input  logic       acc_zero,
  output logic [7:0] ir,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       opnd_load,
  output logic       acc_write,
  output logic [1:0] acc_dst,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_OPND   = 3'b011,
    S_EXEC   = 3'b100,
    S_MEM    = 3'b101,
    S_WB     = 3'b110
  } state_t;

  state_t     cur, nxt;
  state_t     done_st;
  logic       go_fetch;
  logic [7:0] ir_q;

  logic is_nop, is_jump, is_save, is_load, is_loadi, is_sll, is_alu, is_bz, is_ill;

`ifdef GCORE_SEQ_STEP_EN
  assign done_st  = step_mode ? S_IDLE : S_FETCH;
  assign go_fetch = !step_mode || step;
`else
  assign done_st  = S_FETCH;
  assign go_fetch = 1'b1;
`endif

  always_comb begin
    is_nop   = 1'b0;
    is_jump  = 1'b0;
    is_save  = 1'b0;
    is_load  = 1'b0;
    is_loadi = 1'b0;
    is_sll   = 1'b0;
    is_alu   = 1'b0;
    is_bz    = 1'b0;
    is_ill   = 1'b0;
    case (ir_q[7:4])
      4'b0000: is_nop   = 1'b1;
      4'b0001: is_jump  = 1'b1;
      4'b0010: is_save  = 1'b1;
      4'b0011: is_load  = 1'b1;
      4'b0100: is_loadi = 1'b1;
      4'b0101: is_sll   = 1'b1;
      4'b1111: is_bz    = 1'b1;
      4'b0110, 4'b0111, 4'b1101: is_ill = 1'b1;
      default: is_alu   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= S_IDLE;
      ir_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && mem_ready)
        ir_q <= mem_rdata;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (go_fetch) nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (is_nop || is_ill) nxt = done_st;
        else if (is_sll)      nxt = S_EXEC;
        else                  nxt = S_OPND;
      end
      S_OPND:   if (mem_ready) nxt = (is_save || is_load || is_alu) ? S_MEM : S_EXEC;
      S_EXEC:   nxt = done_st;
      S_MEM:    if (mem_ready) nxt = is_save ? done_st : S_WB;
      S_WB:     nxt = done_st;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    opnd_load = 1'b0;
    acc_write = 1'b0;
    illegal   = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        pc_inc  = mem_ready;
      end
      S_DECODE: illegal = is_ill;
      S_OPND: begin
        mem_req   = 1'b1;
        pc_inc    = mem_ready;
        opnd_load = mem_ready;
      end
      S_EXEC: begin
        pc_load   = is_jump || (is_bz && acc_zero);
        acc_write = is_loadi || is_sll;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = is_save;
      end
      S_WB:    acc_write = 1'b1;
      default: ;
    endcase
  end

  // Source select is a pure decode of ir so it is valid wherever acc_write fires.
  always_comb begin
    acc_dst = 2'b00;
    if (is_loadi)    acc_dst = 2'b01;
    else if (is_alu) acc_dst = 2'b10;
    else if (is_sll) acc_dst = 2'b11;
  end

  assign ir     = ir_q;
  assign alu_op = ir_q[6:4];
  assign state  = cur;

endmodule

// File: tb/tb_gcore_seq.sv
// Directed cycle-by-cycle bench for gcore_seq; step-mode checks are compiled
// in only when GCORE_SEQ_STEP_EN is defined.
module tb_gcore_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req, mem_we, mem_sel;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       acc_zero = 1'b0;
  logic [7:0] ir;
  logic       pc_inc, pc_load, opnd_load, acc_write, illegal;
  logic [1:0] acc_dst;
  logic [2:0] alu_op;
  logic [2:0] state;
`ifdef GCORE_SEQ_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam logic [2:0] ID = 3'd0, FE = 3'd1, DE = 3'd2, OP = 3'd3,
                         EX = 3'd4, ME = 3'd5, WB = 3'd6;
  // mem field: {req, sel, we}
  localparam logic [2:0] NOMEM = 3'b000, RDPC = 3'b100, RDOP = 3'b110, WROP = 3'b111;
  // strobe field: {pc_inc, pc_load, opnd_load, acc_write, illegal}
  localparam logic [4:0] NONE = 5'b00000, INC = 5'b10000, PLD = 5'b01000,
                         INCOP = 5'b10100, AW = 5'b00010, ILL = 5'b00001;

  gcore_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef GCORE_SEQ_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .acc_zero  (acc_zero),
    .ir        (ir),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .opnd_load (opnd_load),
    .acc_write (acc_write),
    .acc_dst   (acc_dst),
    .alu_op    (alu_op),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [12:0] obs();
    return {state, mem_req, mem_sel, mem_we,
            pc_inc, pc_load, opnd_load, acc_write, illegal, acc_dst};
  endfunction

  // Drive inputs for one cycle, check outputs mid-cycle, then advance to the next low phase.
  task automatic cy(input string tag, input logic rdy, input logic [7:0] rd, input logic az,
                    input logic [2:0] st, input logic [2:0] mem, input logic [4:0] strb,
                    input logic [1:0] dst);
    mem_ready = rdy;
    mem_rdata = rd;
    acc_zero  = az;
    #1;
    check(tag, {19'd0, obs()}, {19'd0, st, mem, strb, dst});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_vec", {19'd0, obs()}, 32'd0);
    check("reset_ir", {24'd0, ir}, 32'h00);
    check("reset_aluop", {29'd0, alu_op}, 32'd0);
    rst_n = 1'b1;

    // ready high in IDLE must be ignored
    cy("nop_idle",   1, 8'h00, 0, ID, NOMEM, NONE, 2'b00);
    cy("nop_fetch",  1, 8'h00, 0, FE, RDPC,  INC,  2'b00);
    cy("nop_decode", 0, 8'h00, 0, DE, NOMEM, NONE, 2'b00);

    cy("ldi_fetch",  1, 8'h40, 0, FE, RDPC,  INC,   2'b00);
    cy("ldi_decode", 0, 8'h00, 0, DE, NOMEM, NONE,  2'b01);
    cy("ldi_opnd",   1, 8'h5A, 0, OP, RDPC,  INCOP, 2'b01);
    cy("ldi_exec",   0, 8'h00, 0, EX, NOMEM, AW,    2'b01);
    check("ldi_ir", {24'd0, ir}, 32'h40);

    cy("bz1_fetch",  1, 8'hF0, 0, FE, RDPC,  INC,   2'b01);
    cy("bz1_decode", 0, 8'h00, 0, DE, NOMEM, NONE,  2'b00);
    cy("bz1_opnd",   1, 8'h10, 0, OP, RDPC,  INCOP, 2'b00);
    cy("bz1_exec",   0, 8'h00, 1, EX, NOMEM, PLD,   2'b00);
    cy("bz0_fetch",  1, 8'hF0, 0, FE, RDPC,  INC,   2'b00);
    cy("bz0_decode", 0, 8'h00, 1, DE, NOMEM, NONE,  2'b00);
    cy("bz0_opnd",   1, 8'h10, 1, OP, RDPC,  INCOP, 2'b00);
    cy("bz0_exec",   0, 8'h00, 0, EX, NOMEM, NONE,  2'b00);

    cy("alu_fetch",  1, 8'hA0, 0, FE, RDPC,  INC,   2'b00);
    check("alu_op", {29'd0, alu_op}, 32'd2);
    cy("alu_decode", 0, 8'h00, 0, DE, NOMEM, NONE,  2'b10);
    cy("alu_opnd",   1, 8'h33, 0, OP, RDPC,  INCOP, 2'b10);
    cy("alu_mem_w1", 0, 8'h00, 0, ME, RDOP,  NONE,  2'b10);
    cy("alu_mem_w2", 0, 8'h00, 0, ME, RDOP,  NONE,  2'b10);
    cy("alu_mem_w3", 0, 8'h00, 0, ME, RDOP,  NONE,  2'b10);
    cy("alu_mem_rd", 1, 8'h0F, 0, ME, RDOP,  NONE,  2'b10);
    cy("alu_wb",     0, 8'h00, 0, WB, NOMEM, AW,    2'b10);
    check("alu_op_held", {29'd0, alu_op}, 32'd2);

    cy("ill_fetch_w", 0, 8'h00, 0, FE, RDPC,  NONE, 2'b10);
    cy("ill_fetch",   1, 8'h70, 0, FE, RDPC,  INC,  2'b10);
    cy("ill_decode",  0, 8'h00, 0, DE, NOMEM, ILL,  2'b00);

    cy("sll_fetch",  1, 8'h53, 0, FE, RDPC,  INC,  2'b00);
    check("sll_ir", {24'd0, ir}, 32'h53);
    cy("sll_decode", 0, 8'h00, 0, DE, NOMEM, NONE, 2'b11);
    cy("sll_exec",   0, 8'h00, 0, EX, NOMEM, AW,   2'b11);

    cy("jmp_fetch",  1, 8'h10, 0, FE, RDPC,  INC,   2'b11);
    cy("jmp_decode", 0, 8'h00, 0, DE, NOMEM, NONE,  2'b00);
    cy("jmp_opnd",   1, 8'h80, 0, OP, RDPC,  INCOP, 2'b00);
    cy("jmp_exec",   0, 8'h00, 0, EX, NOMEM, PLD,   2'b00);

    cy("ld_fetch",  1, 8'h30, 0, FE, RDPC,  INC,   2'b00);
    cy("ld_decode", 0, 8'h00, 0, DE, NOMEM, NONE,  2'b00);
    cy("ld_opnd",   1, 8'h44, 0, OP, RDPC,  INCOP, 2'b00);
    cy("ld_mem",    1, 8'h99, 0, ME, RDOP,  NONE,  2'b00);
    cy("ld_wb",     0, 8'h00, 0, WB, NOMEM, AW,    2'b00);

    cy("sv_fetch",  1, 8'h20, 0, FE, RDPC,  INC,   2'b00);
    cy("sv_decode", 0, 8'h00, 0, DE, NOMEM, NONE,  2'b00);
    cy("sv_opnd",   1, 8'h55, 0, OP, RDPC,  INCOP, 2'b00);
    cy("sv_mem_w",  0, 8'h00, 0, ME, WROP,  NONE,  2'b00);
    check("sv_mem_hold", {29'd0, state}, {29'd0, ME});
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_state", {29'd0, state}, {29'd0, ID});
    @(negedge clk);
    rst_n = 1'b1;
    cy("arst_idle",  0, 8'h00, 0, ID, NOMEM, NONE, 2'b00);
    cy("arst_fetch", 1, 8'h00, 0, FE, RDPC,  INC,  2'b00);
    cy("arst_dec",   0, 8'h00, 0, DE, NOMEM, NONE, 2'b00);

`ifdef GCORE_SEQ_STEP_EN
    rst_n = 1'b0;
    step_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cy("stp_idle1", 0, 8'h00, 0, ID, NOMEM, NONE, 2'b00);
    cy("stp_idle2", 0, 8'h00, 0, ID, NOMEM, NONE, 2'b00);
    step = 1'b1;
    cy("stp_go",    0, 8'h00, 0, ID, NOMEM, NONE, 2'b00);
    step = 1'b0;
    cy("stp_fetch", 1, 8'h51, 0, FE, RDPC,  INC,  2'b00);
    cy("stp_dec",   0, 8'h00, 0, DE, NOMEM, NONE, 2'b11);
    cy("stp_exec",  0, 8'h00, 0, EX, NOMEM, AW,   2'b11);
    cy("stp_done1", 1, 8'h00, 0, ID, NOMEM, NONE, 2'b11);
    cy("stp_done2", 0, 8'h00, 0, ID, NOMEM, NONE, 2'b11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
